// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the instruction fetch stage.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instruction, pc_plus4} holding register that parks a fetched word
// while ID is stalled. load has priority over drop.
module if_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch stage with IF/ID register, skid buffer and redirect handling.
// Define FETCH_DELAY_SLOT_EN to execute the branch delay slot instead of flushing it.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_if_id,
  output logic [31:0] pc_plus4_if_id,
  output logic        valid_if_id
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_drop, skid_valid;
  logic [31:0]  skid_instr, skid_pc_plus4;
  logic         redirect;
  logic [31:0]  redirect_pc, seq_pc;

  assign redirect    = ~stall_id & (branch_taken | jump_taken);
  assign redirect_pc = branch_taken ? (branch_target & ~32'h3)
                                    : {pc_plus4_q[31:28], jump_address, 2'b00};
  assign seq_pc      = pc_q + PC_STEP;
  assign imem_req    = (state_q == REQ) & ~rst;
  assign imem_addr   = pc_q;

`ifdef FETCH_DELAY_SLOT_EN
  // redir_pend_q: a redirect waiting for its delay-slot word to be accepted.
  logic [31:0] accept_pc;
  assign accept_pc = redirect ? redirect_pc : (redir_pend_q ? redir_pc_q : seq_pc);
`endif

  if_skid_buffer u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .drop         (skid_drop),
    .instr_in     (imem_rdata),
    .pc_plus4_in  (seq_pc),
    .instr_out    (skid_instr),
    .pc_plus4_out (skid_pc_plus4),
    .valid_out    (skid_valid)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    skid_load    = 1'b0;
    skid_drop    = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    case (state_q)
      REQ: begin
        if (imem_ready && stall_id) begin
          skid_load = 1'b1;
          state_d   = HOLD;
        end else if (imem_ready) begin
          instr_d      = imem_rdata;
          pc_plus4_d   = seq_pc;
          valid_d      = 1'b1;
          pc_d         = accept_pc;
          redir_pend_d = 1'b0;
        end else if (!stall_id) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (redirect) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redirect_pc;
          end
        end
      end
      HOLD: begin
        if (!stall_id && skid_valid) begin
          instr_d      = skid_instr;
          pc_plus4_d   = skid_pc_plus4;
          valid_d      = 1'b1;
          pc_d         = accept_pc;
          redir_pend_d = 1'b0;
          skid_drop    = 1'b1;
          state_d      = REQ;
        end
      end
      default: state_d = REQ;
    endcase
`else
    // redir_pend_q is the kill flag: the outstanding response is stale and
    // redir_pc_q is loaded into the PC once it has been absorbed.
    case (state_q)
      REQ: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d         = redirect_pc;
            redir_pend_d = 1'b0;
          end else begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redirect_pc;
          end
        end else if (imem_ready && redir_pend_q) begin
          pc_d         = redir_pc_q;
          redir_pend_d = 1'b0;
          if (!stall_id) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end else if (imem_ready && stall_id) begin
          skid_load = 1'b1;
          state_d   = HOLD;
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          pc_plus4_d = seq_pc;
          valid_d    = 1'b1;
          pc_d       = seq_pc;
        end else if (!stall_id) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_drop = 1'b1;
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          pc_d      = redirect_pc;
          state_d   = REQ;
        end else if (!stall_id && skid_valid) begin
          instr_d    = skid_instr;
          pc_plus4_d = skid_pc_plus4;
          valid_d    = 1'b1;
          pc_d       = seq_pc;
          skid_drop  = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_plus4_q   <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
    end
  end

  assign instruction_if_id = instr_q;
  assign pc_plus4_if_id    = pc_plus4_q;
  assign valid_if_id       = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, multi-cycle
// sequences and a randomized run checked against an instruction-stream model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall_id, branch_taken, jump_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic [25:0] jump_address;
  logic        imem_req, valid_if_id;
  logic [31:0] imem_addr, instruction_if_id, pc_plus4_if_id;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int wait_cnt = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_q[$];

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_id          (stall_id),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump_taken        (jump_taken),
    .jump_address      (jump_address),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .instruction_if_id (instruction_if_id),
    .pc_plus4_if_id    (pc_plus4_if_id),
    .valid_if_id       (valid_if_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_0007;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: memory responds, request-stability is checked, clock advances.
  // Entered and left at a falling edge with control inputs already driven.
  task automatic tick();
    #1;
    if (prev_pend && !rst) begin
      chk("req_held", 32'(imem_req), 32'h1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (imem_req === 1'b1) begin
      imem_ready = (wait_cnt >= lat);
      imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    prev_pend = (imem_req === 1'b1) && !imem_ready && !rst;
    prev_addr = imem_addr;
    @(posedge clk);
    wait_cnt = prev_pend ? wait_cnt + 1 : 0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_instr"}, instruction_if_id, 32'h0);
    chk({tag, "_pc4"},   pc_plus4_if_id, 32'h0);
    chk({tag, "_valid"}, 32'(valid_if_id), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_id = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    branch_target = 32'h0; jump_address = 26'h0; lat = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] btgt;
    logic        jmp;
    logic [25:0] jaddr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] cur, pc4, tgt;
    int idle;
    int kind;

    rst = 1'b1; stall_id = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    branch_target = 32'h0; jump_address = 26'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2001_0005, 32'h4,  1'b1, 1'b1, 32'h4};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2002_0007, 32'h8,  1'b1, 1'b1, 32'h8};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2002_0007, 32'h8,  1'b1, 1'b0, 32'h8};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2002_0007, 32'h8,  1'b1, 1'b0, 32'h8};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2002_0007, 32'h8,  1'b1, 1'b0, 32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'hC0DE_0008, 32'hC,  1'b1, 1'b1, 32'hC};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'hC0DE_000C, 32'h10, 1'b1, 1'b1, 32'h10};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 26'h40,      32'h0,         32'h10, 1'b0, 1'b1, 32'h100};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'hC0DE_0100, 32'h104, 1'b1, 1'b1, 32'h104};
    vecs[9]  = '{1'b0, 1'b1, 32'h203,       1'b1, 26'h3FF_FFFF, 32'h0,        32'h104, 1'b0, 1'b1, 32'h200};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'hC0DE_0200, 32'h204, 1'b1, 1'b1, 32'h204};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,       32'h0,         32'h204, 1'b0, 1'b1, 32'hFFFF_FFFC};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'h3F21_FFFC, 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2001_0005, 32'h4,  1'b1, 1'b1, 32'h4};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       32'h2001_0005, 32'h4,  1'b1, 1'b0, 32'h4};
    vecs[15] = '{1'b0, 1'b1, 32'h40,        1'b0, 26'h0,       32'h0,         32'h4,  1'b0, 1'b1, 32'h40};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       32'hC0DE_0040, 32'h44, 1'b1, 1'b1, 32'h44};

    @(negedge clk);
    do_reset();

`ifndef FETCH_DELAY_SLOT_EN
    // Directed table with zero-wait memory
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      stall_id      = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].btgt;
      jump_taken    = vecs[i].jmp;
      jump_address  = vecs[i].jaddr;
      tick();
      chk($sformatf("v%0d_instr", i), instruction_if_id, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i),   pc_plus4_if_id, vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i), 32'(valid_if_id), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
    end
    branch_taken = 1'b0; jump_taken = 1'b0; stall_id = 1'b0;

    // Branch while a 2-cycle request is outstanding: stale word is killed
    do_reset();
    rst = 1'b0; lat = 2;
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    chk("kill_addr_hold", imem_addr, 32'h0);
    chk("kill_valid0", 32'(valid_if_id), 32'h0);
    tick();
    chk("kill_addr_tgt", imem_addr, 32'h100);
    chk("kill_valid1", 32'(valid_if_id), 32'h0);
    chk("kill_instr1", instruction_if_id, 32'h0);
    tick();
    chk("kill_valid2", 32'(valid_if_id), 32'h0);
    tick();
    chk("kill_valid3", 32'(valid_if_id), 32'h0);
    tick();
    chk("kill_tgt_instr", instruction_if_id, 32'hC0DE_0100);
    chk("kill_tgt_pc4", pc_plus4_if_id, 32'h104);
    chk("kill_tgt_valid", 32'(valid_if_id), 32'h1);
`else
    // Delay slot: branch at 0x20 to 0x80, word at 0x24 still executes
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("ds_branch_instr", instruction_if_id, 32'hC0DE_0020);
    chk("ds_branch_pc4", pc_plus4_if_id, 32'h24);
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    chk("ds_slot_instr", instruction_if_id, 32'hC0DE_0024);
    chk("ds_slot_pc4", pc_plus4_if_id, 32'h28);
    chk("ds_slot_valid", 32'(valid_if_id), 32'h1);
    chk("ds_slot_addr", imem_addr, 32'h80);
    tick();
    chk("ds_tgt_instr", instruction_if_id, 32'hC0DE_0080);
    chk("ds_tgt_pc4", pc_plus4_if_id, 32'h84);
    chk("ds_tgt_valid", 32'(valid_if_id), 32'h1);
`endif

    // Reset asserted while a slow request is outstanding
    do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_instr", instruction_if_id, 32'hC0DE_0008);
    lat = 3;
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0; lat = 0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    tick();
    chk("post_rst_instr", instruction_if_id, 32'h2001_0005);
    chk("post_rst_valid", 32'(valid_if_id), 32'h1);

    // Randomized run against the instruction-stream model
    do_reset();
    rst = 1'b0;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_id      = ($urandom_range(0, 3) == 0);
      branch_taken  = 1'b0;
      jump_taken    = 1'b0;
      branch_target = $urandom;
      jump_address  = 26'($urandom);
      if (wait_cnt == 0) lat = $urandom_range(0, 2);
      if (valid_if_id && !stall_id) begin
        logic allow_redir;
        allow_redir = (exp_q.size() == 1);
        cur = exp_q.pop_front();
        pc4 = cur + 32'd4;
        chk("stream_instr", instruction_if_id, mem_word(cur));
        chk("stream_pc4", pc_plus4_if_id, pc4);
        if (exp_q.size() == 0) exp_q.push_back(pc4);
        idle = 0;
        if (allow_redir && $urandom_range(0, 5) == 0) begin
          kind = $urandom_range(0, 2);
          if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          else branch_target = 32'($urandom_range(0, 4095));
          branch_taken = (kind != 1);
          jump_taken   = (kind != 0);
          if (branch_taken) tgt = branch_target & ~32'h3;
          else tgt = {pc4[31:28], jump_address, 2'b00};
`ifdef FETCH_DELAY_SLOT_EN
          exp_q.push_back(tgt);
`else
          exp_q.delete();
          exp_q.push_back(tgt);
`endif
        end
      end else begin
        idle++;
      end
      if (idle > 60) begin
        chk("stream_watchdog", 32'(idle), 32'h0);
        break;
      end
      tick();
    end
    stall_id = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
